// File: rtl/led_pkg.sv
// Shared constants for the LED blinker and rate meter: class codes, FSM states,
// default blink limits and the window-compare helper.
package led_pkg;

  typedef enum logic [2:0] {
    CLASS_NONE = 3'd0,
    CLASS_10HZ = 3'd1,
    CLASS_5HZ  = 3'd2,
    CLASS_2HZ  = 3'd3,
    CLASS_1HZ  = 3'd4
  } class_e;

  typedef enum logic {
    ST_IDLE,
    ST_MEASURE
  } state_e;

  localparam int unsigned LIMIT_10HZ = 1250000;
  localparam int unsigned LIMIT_5HZ  = 2500000;
  localparam int unsigned LIMIT_2HZ  = 6250000;
  localparam int unsigned LIMIT_1HZ  = 12500000;

  // True when |meas - expected| <= expected >> shift.
  function automatic logic in_window(input logic [31:0] meas, input logic [31:0] expected,
                                     input int unsigned shift);
    logic [31:0] diff;
    diff = (meas >= expected) ? (meas - expected) : (expected - meas);
    return diff <= (expected >> shift);
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer plus previous-value register; flags any rise or fall.
module edge_sync (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Sig,
  output logic o_Edge
);

  logic sync1_q, sync2_q, prev_q;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= i_Sig;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign o_Edge = sync2_q ^ prev_q;

endmodule

// File: rtl/led_rate_meter.sv
// Measures the half-period of an asynchronous square wave in clock cycles and
// classifies it against the 10/5/2/1 Hz blink limits, with lock and timeout flags.
module led_rate_meter
  import led_pkg::*;
#(
  parameter int unsigned g_limit_for_10Hz = LIMIT_10HZ,
  parameter int unsigned g_limit_for_5Hz  = LIMIT_5HZ,
  parameter int unsigned g_limit_for_2Hz  = LIMIT_2HZ,
  parameter int unsigned g_limit_for_1Hz  = LIMIT_1HZ,
  parameter int unsigned g_tol_shift      = 3,
  parameter int unsigned g_timeout        = 25000000
) (
  input  logic        i_Clk,
  input  logic        i_Rst_L,
  input  logic        i_Sig,
  output logic [31:0] o_Half_Period,
  output logic        o_Valid,
  output logic [2:0]  o_Class,
  output logic        o_Locked,
  output logic        o_Timeout
);

  localparam logic [31:0] EXP_10HZ = 32'(g_limit_for_10Hz + 1);
  localparam logic [31:0] EXP_5HZ  = 32'(g_limit_for_5Hz + 1);
  localparam logic [31:0] EXP_2HZ  = 32'(g_limit_for_2Hz + 1);
  localparam logic [31:0] EXP_1HZ  = 32'(g_limit_for_1Hz + 1);
  localparam logic [31:0] TIMEOUT  = 32'(g_timeout);

  logic        sig_edge;
  logic [31:0] cnt_q, meas;
  logic [31:0] half_period_q;
  logic        valid_q, locked_q, timeout_q;
  class_e      class_q, new_class;
  state_e      state_q;
  logic [3:0]  hit;

  edge_sync u_edge_sync (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_Sig   (i_Sig),
    .o_Edge  (sig_edge)
  );

  // Cycles since the last edge, counting the current edge cycle.
  assign meas = cnt_q + 32'd1;

  always_comb begin
    hit[0] = in_window(meas, EXP_10HZ, g_tol_shift);
    hit[1] = in_window(meas, EXP_5HZ, g_tol_shift);
    hit[2] = in_window(meas, EXP_2HZ, g_tol_shift);
    hit[3] = in_window(meas, EXP_1HZ, g_tol_shift);
    new_class = CLASS_NONE;
    if (hit[0])      new_class = CLASS_10HZ;
    else if (hit[1]) new_class = CLASS_5HZ;
    else if (hit[2]) new_class = CLASS_2HZ;
    else if (hit[3]) new_class = CLASS_1HZ;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      half_period_q <= '0;
      valid_q       <= 1'b0;
      class_q       <= CLASS_NONE;
      locked_q      <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // The first edge only arms: no previous edge to measure from.
          if (sig_edge) begin
            state_q   <= ST_MEASURE;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
          end
        end
        ST_MEASURE: begin
          if (sig_edge) begin
            cnt_q         <= '0;
            half_period_q <= meas;
            valid_q       <= 1'b1;
            class_q       <= new_class;
            locked_q      <= (new_class == class_q) && (new_class != CLASS_NONE);
          end else if (meas == TIMEOUT) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            timeout_q <= 1'b1;
            class_q   <= CLASS_NONE;
            locked_q  <= 1'b0;
          end else begin
            cnt_q <= meas;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_Half_Period = half_period_q;
  assign o_Valid       = valid_q;
  assign o_Class       = class_q;
  assign o_Locked      = locked_q;
  assign o_Timeout     = timeout_q;

endmodule
